// File: rtl/chunked_addsub_if.sv
// rtl/chunked_addsub_if.sv - operand/result handshake bundle for chunked_addsub
interface chunked_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, sum, cout, ovf, zero
    );

    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero
    );
endinterface

// File: rtl/chunked_addsub.sv
// rtl/chunked_addsub.sv - multi-cycle adder/subtractor, CHUNK bits per cycle
module chunked_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    chunked_addsub_if.slave   bus
);
    localparam int NCHUNK = (CHUNK > 0) ? WIDTH / CHUNK : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("chunked_addsub: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_res;

    // b_q already holds ~b for subtraction, so RUN is always a plain add.
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                a_chunk = a_q[i*CHUNK +: CHUNK];
                b_chunk = b_q[i*CHUNK +: CHUNK];
            end
        end
        chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
        sum_d = sum_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                sum_d[i*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b ^ {WIDTH{bus.sub}};
                        carry_q <= bus.cin ^ bus.sub;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= chunk_res[CHUNK];
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        // Carry into the MSB is recovered as a^b^s at that bit.
                        cout_q      <= chunk_res[CHUNK];
                        ovf_q       <= a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_d[WIDTH-1] ^ chunk_res[CHUNK];
                        zero_q      <= (sum_d == '0);
                        out_valid_q <= 1'b1;
                        cnt_q       <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_chunked_addsub.sv
// tb/tb_chunked_addsub.sv - scoreboard bench: directed cases on CHUNK=8, random on CHUNK 1/4/8/32
module tb_chunked_addsub;
    localparam int W      = 32;
    localparam int N_OPS  = 600;
    localparam int TMO    = 50000;

    typedef logic [W+2:0] exp_t;   // {sum, cout, ovf, zero}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_d_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_rand_done = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual=event required=none", name);
    endtask

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        logic [W-1:0] bb;
        logic         c;
        logic [W:0]   full;
        longint       s;
        logic         ovf;
        bb   = sub ? ~b : b;
        c    = sub ? ~cin : cin;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        s    = longint'($signed(a)) + longint'($signed(bb)) + longint'(c);
        ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {full[W-1:0], full[W], ovf, full[W-1:0] == '0};
    endfunction

    function automatic logic [W-1:0] rnd_word();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return '1;
            2: return 32'h7FFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    // ---------------- directed instance ----------------
    chunked_addsub_if #(.WIDTH(W)) bd();
    chunked_addsub #(.WIDTH(W), .CHUNK(8)) dut_d (.clk(clk), .rst_n(rst_d_n), .bus(bd));
    exp_t q_d[$];
    exp_t e_d;

    initial begin : mon_d
        forever begin
            @(negedge clk);
            if (rst_d_n && bd.out_valid && bd.out_ready) begin
                if (q_d.size() == 0) fail_now("d_unexpected_output");
                else begin
                    e_d = q_d.pop_front();
                    check("d_result", {bd.sum, bd.cout, bd.ovf, bd.zero}, e_d);
                end
            end
        end
    end

    task automatic issue_d(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub, input exp_t req);
        int t;
        @(posedge clk); #1;
        bd.in_valid = 1'b1; bd.a = a; bd.b = b; bd.cin = cin; bd.sub = sub;
        t = 0;
        while (!bd.in_ready && t < 100) begin @(posedge clk); #1; t++; end
        if (t >= 100) begin
            fail_now("d_accept_timeout");
            bd.in_valid = 1'b0;
        end else begin
            q_d.push_back(req);
            @(posedge clk); #1;
            bd.in_valid = 1'b0;
            bd.a = ~a; bd.b = ~b; bd.cin = ~cin; bd.sub = ~sub;
        end
    endtask

    task automatic wait_idle_d();
        int t;
        t = 0;
        while ((q_d.size() != 0 || !bd.in_ready) && t < 200) begin @(posedge clk); #1; t++; end
        if (t >= 200) fail_now("d_idle_timeout");
    endtask

    // ---------------- random instances ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int CHV = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 8 : 32;
        chunked_addsub_if #(.WIDTH(W)) br();
        chunked_addsub #(.WIDTH(W), .CHUNK(CHV)) dut (.clk(clk), .rst_n(rst_n), .bus(br));
        exp_t         q[$];
        exp_t         e;
        int           n_got;
        int           t;
        int           mcyc;
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        initial begin : drv
            br.in_valid = 1'b0; br.a = '0; br.b = '0; br.cin = 1'b0; br.sub = 1'b0;
            wait (rst_n === 1'b1);
            @(posedge clk); #1;
            for (int i = 0; i < N_OPS; i++) begin
                ra = rnd_word(); rb = rnd_word();
                rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
                br.in_valid = 1'b1; br.a = ra; br.b = rb; br.cin = rc; br.sub = rs;
                t = 0;
                while (!br.in_ready && t < 200) begin @(posedge clk); #1; t++; end
                if (t >= 200) begin
                    fail_now($sformatf("r%0d_accept_timeout", CHV));
                    break;
                end
                q.push_back(model(ra, rb, rc, rs));
                @(posedge clk); #1;
                // Garbage while busy: must be ignored and must not disturb the result.
                br.in_valid = 1'($urandom_range(0, 1));
                br.a = $urandom; br.b = $urandom; br.cin = 1'($urandom); br.sub = 1'($urandom);
                @(posedge clk); #1;
                br.in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            br.in_valid = 1'b0;
        end

        initial begin : mon
            br.out_ready = 1'b0;
            n_got = 0;
            mcyc = 0;
            wait (rst_n === 1'b1);
            while (n_got < N_OPS && mcyc < TMO) begin
                @(negedge clk);
                if (br.out_valid && br.out_ready) begin
                    if (q.size() == 0) fail_now($sformatf("r%0d_unexpected_output", CHV));
                    else begin
                        e = q.pop_front();
                        check($sformatf("r%0d_result", CHV), {br.sum, br.cout, br.ovf, br.zero}, e);
                        n_got++;
                    end
                end
                @(posedge clk); #1;
                br.out_ready = ($urandom_range(0, 3) != 0);
                mcyc++;
            end
            if (n_got < N_OPS) fail_now($sformatf("r%0d_op_timeout", CHV));
            n_rand_done++;
        end
    end

    // ---------------- directed sequence and summary ----------------
    initial begin : main
        int t;
        rst_n = 1'b0; rst_d_n = 1'b0;
        bd.in_valid = 1'b0; bd.a = '0; bd.b = '0; bd.cin = 1'b0; bd.sub = 1'b0; bd.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bd.out_valid, 0);
        check("rst_sum", bd.sum, 0);
        check("rst_flags", {bd.cout, bd.ovf, bd.zero}, 0);
        check("rst_in_ready", bd.in_ready, 0);
        rst_n = 1'b1; rst_d_n = 1'b1;
        #1;
        check("post_rst_in_ready", bd.in_ready, 1);

        // T1 plus exact latency
        issue_d(32'h0000_00FF, 32'h1, 1'b0, 1'b0, {32'h0000_0100, 1'b0, 1'b0, 1'b0});
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("t1_latency_c%0d", i), bd.out_valid, (i == 4));
        end
        wait_idle_d();

        // T2, T3 and subtraction corners
        issue_d(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, {32'h0, 1'b1, 1'b0, 1'b1});
        wait_idle_d();
        issue_d(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1, 1'b0});
        wait_idle_d();
        issue_d(32'd5, 32'd7, 1'b0, 1'b1, {32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
        wait_idle_d();
        issue_d(32'h0, 32'h0, 1'b1, 1'b1, {32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
        wait_idle_d();
        issue_d(32'h8000_0000, 32'h1, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
        wait_idle_d();

        // T4 backpressure
        bd.out_ready = 1'b0;
        issue_d(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, {32'h2345_6789, 1'b0, 1'b0, 1'b0});
        t = 0;
        while (!bd.out_valid && t < 50) begin @(posedge clk); #1; t++; end
        if (t >= 50) fail_now("t4_out_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            bd.in_valid = 1'b1; bd.a = $urandom; bd.b = $urandom;
            @(posedge clk); #1;
            check("t4_hold_in_ready", bd.in_ready, 0);
            check("t4_hold_out_valid", bd.out_valid, 1);
            check("t4_hold_result", {bd.sum, bd.cout, bd.ovf, bd.zero}, {32'h2345_6789, 3'b000});
        end
        bd.in_valid = 1'b0;
        bd.out_ready = 1'b1;
        @(posedge clk); #1;
        check("t4_in_ready_after_hs", bd.in_ready, 1);
        check("t4_out_valid_after_hs", bd.out_valid, 0);
        check("t4_sum_held", bd.sum, 32'h2345_6789);
        wait_idle_d();

        // T5 reset in the middle of RUN
        issue_d(32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 1'b0, {32'h0001_FFFE, 1'b0, 1'b0, 1'b0});
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_d_n = 1'b0;
        void'(q_d.pop_back());
        #1;
        check("t5_out_valid", bd.out_valid, 0);
        check("t5_sum", bd.sum, 0);
        check("t5_flags", {bd.cout, bd.ovf, bd.zero}, 0);
        check("t5_in_ready", bd.in_ready, 0);
        @(posedge clk); #1;
        rst_d_n = 1'b1;
        issue_d(32'd3, 32'd4, 1'b0, 1'b0, {32'd7, 1'b0, 1'b0, 1'b0});
        wait_idle_d();
        repeat (5) @(posedge clk);
        #1;
        check("d_queue_empty", q_d.size(), 0);

        t = 0;
        while (n_rand_done < 4 && t < TMO + 1000) begin @(posedge clk); t++; end
        if (n_rand_done < 4) fail_now("random_runs_timeout");
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: check("r1_queue_empty", g_rand[0].q.size(), 0);
                1: check("r4_queue_empty", g_rand[1].q.size(), 0);
                2: check("r8_queue_empty", g_rand[2].q.size(), 0);
                default: check("r32_queue_empty", g_rand[3].q.size(), 0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
